// File: rtl/taitosj_scroll_ctrl.sv
// Taito SJ playfield scroll controller: CPU shadow registers, h-blank commit scan, shifter load strobes.
// Optional build macro TAITOSJ_VSCROLL_LINE_EN makes vertical scroll commits eligible on every blank.

module taitosj_scroll_ctrl (
  input  logic       clkm_48MHZ,
  input  logic       RESET_n,
  input  logic       ce_6m,
  input  logic       HBL,
  input  logic       VBL,
  input  logic [8:0] SB_HN,
  input  logic       cpu_wr,
  input  logic [2:0] cpu_sel,
  input  logic [7:0] cpu_data,
  output logic [7:0] HSCR0,
  output logic [7:0] HSCR1,
  output logic [7:0] HSCR2,
  output logic [7:0] VSCR0,
  output logic [7:0] VSCR1,
  output logic [7:0] VSCR2,
  output logic [5:0] pending,
  output logic       busy,
  output logic [2:0] SNLD_n,
  output logic       commit_miss
);

  // state | meaning
  // IDLE  | active line, waiting for the start of horizontal blank
  // SCAN  | stepping idx 0..5 on ce_6m, committing eligible pending shadows
  // HOLD  | scan finished, waiting for blank to end
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0] state;
  logic [2:0] idx;
  logic       hbl_q;
  logic [7:0] shadow [6];
  logic [7:0] active [6];

  logic       hbl_rise;
  logic       scan_step;
  logic       scan_abort;
  logic       idx_eligible;
  logic [5:0] wr_hit;
  logic [5:0] commit_hit;
  logic       unused_in;

  assign hbl_rise   = ce_6m & HBL & ~hbl_q;
  assign scan_step  = (state == ST_SCAN) & ce_6m & HBL;
  assign scan_abort = (state == ST_SCAN) & ce_6m & ~HBL;

`ifdef TAITOSJ_VSCROLL_LINE_EN
  assign idx_eligible = 1'b1;
  // Coarse counter bits and VBL play no part when vertical scroll is per-line.
  assign unused_in    = ^{SB_HN[8:3], VBL};
`else
  logic vwin;

  assign idx_eligible = (idx < 3'd3) | vwin;
  assign unused_in    = ^SB_HN[8:3];
`endif

  always_comb begin
    wr_hit     = '0;
    commit_hit = '0;
    for (int i = 0; i < 6; i++) begin
      wr_hit[i]     = cpu_wr && (cpu_sel == 3'(i));
      commit_hit[i] = scan_step && idx_eligible && pending[i] && (idx == 3'(i));
    end
  end

  always_ff @(posedge clkm_48MHZ) begin
    if (!RESET_n) begin
      state       <= ST_IDLE;
      idx         <= 3'd0;
      hbl_q       <= 1'b0;
      commit_miss <= 1'b0;
`ifndef TAITOSJ_VSCROLL_LINE_EN
      vwin        <= 1'b0;
`endif
    end else begin
      commit_miss <= scan_abort;
      if (ce_6m)
        hbl_q <= HBL;
      case (state)
        ST_IDLE: begin
          if (hbl_rise) begin
            state <= ST_SCAN;
            idx   <= 3'd0;
`ifndef TAITOSJ_VSCROLL_LINE_EN
            vwin  <= VBL;
`endif
          end
        end
        ST_SCAN: begin
          if (scan_abort)
            state <= ST_IDLE;
          else if (scan_step) begin
            if (idx == 3'd5)
              state <= ST_HOLD;
            else
              idx <= idx + 3'd1;
          end
        end
        ST_HOLD: begin
          if (ce_6m && !HBL)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A write landing on the same index as its commit wins the shadow and keeps it pending.
  always_ff @(posedge clkm_48MHZ) begin
    if (!RESET_n) begin
      pending <= 6'd0;
      for (int i = 0; i < 6; i++) begin
        shadow[i] <= 8'h00;
        active[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (commit_hit[i])
          active[i] <= shadow[i];
        if (wr_hit[i]) begin
          shadow[i]  <= cpu_data;
          pending[i] <= 1'b1;
        end else if (commit_hit[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clkm_48MHZ) begin
    if (!RESET_n)
      SNLD_n <= 3'b111;
    else if (ce_6m) begin
      SNLD_n[0] <= !((SB_HN[2:0] == active[0][2:0]) && !HBL);
      SNLD_n[1] <= !((SB_HN[2:0] == active[1][2:0]) && !HBL);
      SNLD_n[2] <= !((SB_HN[2:0] == active[2][2:0]) && !HBL);
    end
  end

  assign busy  = (state == ST_SCAN);
  assign HSCR0 = active[0];
  assign HSCR1 = active[1];
  assign HSCR2 = active[2];
  assign VSCR0 = active[3];
  assign VSCR1 = active[4];
  assign VSCR2 = active[5];

endmodule

// File: tb/tb_taitosj_scroll_ctrl.sv
// Self-checking bench for taitosj_scroll_ctrl; expectations come from an array-level model of
// shadow/active/pending and blank commits. Honours TAITOSJ_VSCROLL_LINE_EN if defined.

module tb_taitosj_scroll_ctrl;

`ifdef TAITOSJ_VSCROLL_LINE_EN
  localparam bit LINE_EN = 1'b1;
`else
  localparam bit LINE_EN = 1'b0;
`endif

  logic       clk;
  logic       RESET_n;
  logic       ce_6m;
  logic       HBL;
  logic       VBL;
  logic [8:0] SB_HN;
  logic       cpu_wr;
  logic [2:0] cpu_sel;
  logic [7:0] cpu_data;
  logic [7:0] HSCR0, HSCR1, HSCR2, VSCR0, VSCR1, VSCR2;
  logic [5:0] pending;
  logic       busy;
  logic [2:0] SNLD_n;
  logic       commit_miss;

  taitosj_scroll_ctrl dut (
    .clkm_48MHZ (clk),
    .RESET_n    (RESET_n),
    .ce_6m      (ce_6m),
    .HBL        (HBL),
    .VBL        (VBL),
    .SB_HN      (SB_HN),
    .cpu_wr     (cpu_wr),
    .cpu_sel    (cpu_sel),
    .cpu_data   (cpu_data),
    .HSCR0      (HSCR0),
    .HSCR1      (HSCR1),
    .HSCR2      (HSCR2),
    .VSCR0      (VSCR0),
    .VSCR1      (VSCR1),
    .VSCR2      (VSCR2),
    .pending    (pending),
    .busy       (busy),
    .SNLD_n     (SNLD_n),
    .commit_miss(commit_miss)
  );

  logic [7:0] dut_act [6];
  always_comb begin
    dut_act[0] = HSCR0;
    dut_act[1] = HSCR1;
    dut_act[2] = HSCR2;
    dut_act[3] = VSCR0;
    dut_act[4] = VSCR1;
    dut_act[5] = VSCR2;
  end

  logic [7:0] mdl_shadow [6];
  logic [7:0] mdl_active [6];
  logic [5:0] mdl_pend;
  int n_total;
  int n_pass;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ce_6m is high for one clock in eight; updated 1ns after the edge, the main flow acts at 2ns
  initial begin
    logic [2:0] ce_cnt;
    ce_cnt = 3'd0;
    ce_6m  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ce_cnt = ce_cnt + 3'd1;
      ce_6m  = (ce_cnt == 3'd7);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Advance until just past the next clock edge that has ce_6m asserted.
  task automatic next_ce();
    int guard;
    guard = 0;
    while (!ce_6m && guard < 16) begin
      tick();
      guard++;
    end
    tick();
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) begin
      mdl_shadow[i] = 8'h00;
      mdl_active[i] = 8'h00;
    end
    mdl_pend = 6'd0;
  endfunction

  function automatic void model_write(input logic [2:0] sel, input logic [7:0] d);
    if (sel <= 3'd5) begin
      mdl_shadow[sel] = d;
      mdl_pend[sel]   = 1'b1;
    end
  endfunction

  // A blank commits every pending eligible index among the first n_eval evaluated.
  function automatic void model_blank(input bit vbl, input int n_eval);
    for (int i = 0; i < n_eval; i++) begin
      if (mdl_pend[i] && (i < 3 || vbl || LINE_EN)) begin
        mdl_active[i] = mdl_shadow[i];
        mdl_pend[i]   = 1'b0;
      end
    end
  endfunction

  task automatic cpu_write(input logic [2:0] sel, input logic [7:0] d);
    cpu_sel  = sel;
    cpu_data = d;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr   = 1'b0;
    model_write(sel, d);
  endtask

  task automatic do_blank(input bit vbl);
    VBL = vbl;
    HBL = 1'b1;
    next_ce();
    for (int i = 0; i < 6; i++) next_ce();
    HBL = 1'b0;
    next_ce();
    model_blank(vbl, 6);
  endtask

  task automatic test_reset();
    RESET_n = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    model_reset();
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (dut_act[i] !== 8'h00) $display("FAIL reset_active[%0d] got %02h exp 00", i, dut_act[i]);
      else n_pass++;
    end
    n_total++;
    if (pending !== 6'd0) $display("FAIL reset_pending got %b exp 000000", pending);
    else n_pass++;
    n_total++;
    if (SNLD_n !== 3'b111) $display("FAIL reset_snld got %b exp 111", SNLD_n);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || commit_miss !== 1'b0)
      $display("FAIL reset_busy_miss got %b%b exp 00", busy, commit_miss);
    else n_pass++;
    RESET_n = 1'b1;
    tick();
  endtask

  task automatic test_h_commit();
    cpu_write(3'd1, 8'h35);
    n_total++;
    if (pending !== 6'b000010) $display("FAIL hc_pending got %b exp 000010", pending);
    else n_pass++;
    n_total++;
    if (HSCR1 !== 8'h00) $display("FAIL hc_before_blank got %02h exp 00", HSCR1);
    else n_pass++;
    VBL = 1'b0;
    HBL = 1'b1;
    next_ce();
    n_total++;
    if (busy !== 1'b1) $display("FAIL hc_busy_entry got %b exp 1", busy);
    else n_pass++;
    next_ce();
    n_total++;
    if (HSCR1 !== 8'h00) $display("FAIL hc_first_ce got %02h exp 00", HSCR1);
    else n_pass++;
    next_ce();
    n_total++;
    if (HSCR1 !== 8'h35 || pending !== 6'd0)
      $display("FAIL hc_second_ce got %02h/%b exp 35/000000", HSCR1, pending);
    else n_pass++;
    for (int i = 0; i < 4; i++) next_ce();
    n_total++;
    if (busy !== 1'b0) $display("FAIL hc_busy_hold got %b exp 0", busy);
    else n_pass++;
    HBL = 1'b0;
    next_ce();
    model_blank(1'b0, 6);
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (dut_act[i] !== mdl_active[i])
        $display("FAIL hc_active[%0d] got %02h exp %02h", i, dut_act[i], mdl_active[i]);
      else n_pass++;
    end
  endtask

  task automatic test_v_gating();
    logic [7:0] exp_first;
    exp_first = LINE_EN ? 8'h80 : 8'h00;
    cpu_write(3'd3, 8'h80);
    do_blank(1'b0);
    n_total++;
    if (VSCR0 !== exp_first) $display("FAIL vg_first_blank got %02h exp %02h", VSCR0, exp_first);
    else n_pass++;
    n_total++;
    if (pending[3] !== !LINE_EN) $display("FAIL vg_pending got %b exp %b", pending[3], !LINE_EN);
    else n_pass++;
    do_blank(1'b1);
    n_total++;
    if (VSCR0 !== 8'h80 || pending !== mdl_pend)
      $display("FAIL vg_vbl_blank got %02h/%b exp 80/%b", VSCR0, pending, mdl_pend);
    else n_pass++;
  endtask

  task automatic test_collision();
    cpu_write(3'd0, 8'h11);
    VBL = 1'b0;
    HBL = 1'b1;
    next_ce();
    while (!ce_6m) tick();
    cpu_sel  = 3'd0;
    cpu_data = 8'h22;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr   = 1'b0;
    n_total++;
    if (HSCR0 !== 8'h11 || pending[0] !== 1'b1)
      $display("FAIL col_same_cycle got %02h/%b exp 11/1", HSCR0, pending[0]);
    else n_pass++;
    for (int i = 0; i < 5; i++) next_ce();
    HBL = 1'b0;
    next_ce();
    model_blank(1'b0, 6);
    model_write(3'd0, 8'h22);
    n_total++;
    if (pending !== mdl_pend) $display("FAIL col_pending got %b exp %b", pending, mdl_pend);
    else n_pass++;
    do_blank(1'b0);
    n_total++;
    if (HSCR0 !== 8'h22) $display("FAIL col_next_blank got %02h exp 22", HSCR0);
    else n_pass++;
  endtask

  task automatic test_abort();
    int pulses;
    cpu_write(3'd3, 8'hA3);
    cpu_write(3'd4, 8'hA4);
    cpu_write(3'd5, 8'hA5);
    cpu_write(3'd2, 8'h77);
    VBL = 1'b1;
    HBL = 1'b1;
    next_ce();
    for (int i = 0; i < 3; i++) next_ce();
    HBL = 1'b0;
    while (!ce_6m) tick();
    tick();
    model_blank(1'b1, 3);
    n_total++;
    if (commit_miss !== 1'b1 || busy !== 1'b0)
      $display("FAIL abort_pulse got miss=%b busy=%b exp miss=1 busy=0", commit_miss, busy);
    else n_pass++;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (commit_miss) pulses++;
    end
    n_total++;
    if (pulses !== 0) $display("FAIL abort_pulse_len got %0d extra clocks exp 0", pulses);
    else n_pass++;
    n_total++;
    if (pending !== mdl_pend || HSCR2 !== 8'h77)
      $display("FAIL abort_state got %b/%02h exp %b/77", pending, HSCR2, mdl_pend);
    else n_pass++;
    do_blank(1'b1);
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (dut_act[i] !== mdl_active[i])
        $display("FAIL abort_recover[%0d] got %02h exp %02h", i, dut_act[i], mdl_active[i]);
      else n_pass++;
    end
  endtask

  task automatic test_load_strobe();
    int lows;
    logic [2:0] exp;
    cpu_write(3'd2, 8'h05);
    cpu_write(3'd0, 8'($urandom_range(0, 255)));
    cpu_write(3'd1, 8'($urandom_range(0, 255)));
    do_blank(1'b0);
    lows  = 0;
    SB_HN = 9'd0;
    next_ce();
    for (int k = 0; k < 16; k++) begin
      SB_HN = 9'(k + 1);
      for (int n = 0; n < 3; n++) exp[n] = !(3'(k) == mdl_active[n][2:0]);
      for (int c = 0; c < 8; c++) begin
        n_total++;
        if (SNLD_n !== exp)
          $display("FAIL snld hn=%0d clk=%0d got %b exp %b", k, c, SNLD_n, exp);
        else n_pass++;
        if (!SNLD_n[2]) lows++;
        tick();
      end
    end
    n_total++;
    if (lows !== 16) $display("FAIL snld2_low_clocks got %0d exp 16", lows);
    else n_pass++;
    SB_HN = 9'd5;
    HBL   = 1'b1;
    next_ce();
    n_total++;
    if (SNLD_n !== 3'b111) $display("FAIL snld_in_blank got %b exp 111", SNLD_n);
    else n_pass++;
    for (int i = 0; i < 6; i++) next_ce();
    HBL = 1'b0;
    next_ce();
    model_blank(VBL, 6);
  endtask

  task automatic test_random();
    bit vbl;
    for (int it = 0; it < 12; it++) begin
      int nw;
      nw = int'($urandom_range(0, 4));
      for (int w = 0; w < nw; w++) begin
        cpu_write(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        for (int g = 0; g < int'($urandom_range(0, 5)); g++) tick();
      end
      n_total++;
      if (pending !== mdl_pend) $display("FAIL rnd_pending it=%0d got %b exp %b", it, pending, mdl_pend);
      else n_pass++;
      vbl = 1'($urandom_range(0, 1));
      do_blank(vbl);
      for (int i = 0; i < 6; i++) begin
        n_total++;
        if (dut_act[i] !== mdl_active[i])
          $display("FAIL rnd_active it=%0d [%0d] got %02h exp %02h", it, i, dut_act[i], mdl_active[i]);
        else n_pass++;
      end
      n_total++;
      if (pending !== mdl_pend) $display("FAIL rnd_post_pending it=%0d got %b exp %b", it, pending, mdl_pend);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_scan();
    cpu_write(3'd0, 8'h5A);
    cpu_write(3'd4, 8'h44);
    VBL = 1'b1;
    HBL = 1'b1;
    next_ce();
    next_ce();
    RESET_n = 1'b0;
    tick();
    model_reset();
    n_total++;
    if (HSCR0 !== 8'h00 || VSCR1 !== 8'h00 || pending !== 6'd0 || busy !== 1'b0 || SNLD_n !== 3'b111)
      $display("FAIL mid_scan_reset got %02h/%02h/%b/%b/%b exp 00/00/000000/0/111",
               HSCR0, VSCR1, pending, busy, SNLD_n);
    else n_pass++;
    RESET_n = 1'b1;
    HBL     = 1'b0;
    tick();
    cpu_write(3'd1, 8'h19);
    do_blank(1'b0);
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (dut_act[i] !== mdl_active[i])
        $display("FAIL post_reset[%0d] got %02h exp %02h", i, dut_act[i], mdl_active[i]);
      else n_pass++;
    end
  endtask

  initial begin
    n_total  = 0;
    n_pass   = 0;
    RESET_n  = 1'b0;
    HBL      = 1'b0;
    VBL      = 1'b0;
    SB_HN    = 9'd0;
    cpu_wr   = 1'b0;
    cpu_sel  = 3'd0;
    cpu_data = 8'h00;
    model_reset();
    test_reset();
    test_h_commit();
    test_v_gating();
    test_collision();
    test_abort();
    test_load_strobe();
    test_random();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/taitosj_scroll_ctrl.md
# taitosj_scroll_ctrl

Scroll-register controller for the Taito SJ video timing path. It captures Z80 writes to the three playfield scroll registers (horizontal and vertical) into shadow copies. During horizontal blank it commits them to the active copies through a sequenced scan, so raster effects never tear mid-line. From the committed horizontal fine bits and the pixel counter it generates the per-layer active-low shifter load strobes. It sits between the CPU bus decode and the playfield shifters, and is driven by the sync bus counters.

## Interface

- No parameters.

Ports:
- clkm_48MHZ  in  1  system clock; everything is synchronous to it.
- RESET_n  in  1  reset; synchronous to clkm_48MHZ, active-low.
- ce_6m  in  1  pixel clock enable, one clkm_48MHZ cycle in eight.
- HBL  in  1  horizontal blank, high while blanked.
- VBL  in  1  vertical blank, high while blanked.
- SB_HN  in  9  raw horizontal pixel counter.
- cpu_wr  in  1  one-cycle CPU write strobe.
- cpu_sel  in  3  register index:
  - 0..2 select H1..H3.
  - 3..5 select V1..V3.
  - 6 and 7 are ignored.
- cpu_data  in  8  write data.
- HSCR0, HSCR1, HSCR2  out  8 each  active horizontal scroll values.
- VSCR0, VSCR1, VSCR2  out  8 each  active vertical scroll values.
- pending  out  6  shadow-not-committed flag per index.
- busy  out  1  high while the state machine is in SCAN.
- SNLD_n  out  3  per-layer shifter load strobes, active-low.
- commit_miss  out  1  one-cycle pulse when HBL ends during SCAN.

## Operation

Reset:
- All shadow and active registers are 0x00 and all pending flags are 0.
- SNLD_n = 3'b111, busy = 0, commit_miss = 0.
- The state machine is in IDLE.

CPU write (cpu_wr = 1 and cpu_sel ≤ 5):
- Loads shadow[cpu_sel] and sets pending[cpu_sel] on the next clock.
- Writes are accepted in every state and never stall.

HBL edge detect:
- HBL is registered on each ce_6m.
- A rising edge (previous 0, current 1) is `hbl_rise`.

State machine:
- **IDLE:**
  - On `hbl_rise`, latch `vwin = VBL`, set idx = 0 and go to SCAN.
- **SCAN:**
  - On each ce_6m, evaluate idx.
  - A commit happens if pending[idx] is set and idx is eligible. Indices 0..2 are always eligible; indices 3..5 are eligible only when vwin = 1.
  - A commit copies shadow[idx] to active[idx] and clears pending[idx].
  - idx then increments. After idx 5 is evaluated, go to HOLD.
  - If HBL is low on a ce_6m while in SCAN, abort with no commit on that cycle. Pulse commit_miss and go to IDLE.
- **HOLD:**
  - Go to IDLE when HBL is sampled low on ce_6m.

Write colliding with a commit of the same index in the same cycle:
- active[idx] takes the old shadow value.
- shadow takes cpu_data.
- pending[idx] stays 1.

Load strobes:
- SNLD_n[n] is updated only on ce_6m.
- It is registered as 0 when SB_HN[2:0] == HSCRn[2:0] and HBL = 0; otherwise it is 1.

## Timing

- Write to pending: 1 clock.
- Commit: the first index is evaluated on the first ce_6m after the one that detected `hbl_rise`. A full scan takes 6 ce_6m cycles, i.e. 48 clocks.
- HSCRn changes only between the first and sixth ce_6m of a blank. It is stable for the whole active line.
- SNLD_n has 1 ce_6m of latency from the SB_HN match. The pulse lasts exactly one ce_6m period (8 clocks).
- busy is high from SCAN entry until leaving SCAN.
- Reset asserted mid-SCAN returns everything to reset values on the next clock. Pending writes are lost.

## Configuration

- TAITOSJ_VSCROLL_LINE_EN
  - Defined: indices 3..5 are eligible on every blank. Vertical scroll is per-line, and vwin is ignored.
  - Undefined: vertical commits occur only in blanks that start while VBL = 1 (behaviour as specified above).

## Test plan

- **Reset values:** hold RESET_n = 0 for 4 clocks → all HSCR/VSCR = 0x00, pending = 0, SNLD_n = 3'b111, busy = 0.
- **H commit at blank:** write H2 = 0x35 during active line → pending = 6'b000010, HSCR1 stays 0x00. Then `hbl_rise` → HSCR1 = 0x35 on the 2nd ce_6m of SCAN, pending = 0.
- **V commit gating:**
  - Macro undefined: write V1 = 0x80 with VBL = 0 → not committed on that blank. At the next blank with VBL = 1 → VSCR0 = 0x80.
  - Macro defined: VSCR0 = 0x80 at the first blank.
- **Collision:** write H1 = 0x11, then write H1 = 0x22 on the exact clock H1 commits → HSCR0 = 0x11, pending[0] = 1. At the next blank → HSCR0 = 0x22.
- **Abort:** drop HBL after 3 ce_6m of SCAN → commit_miss pulses once for 1 clock, idx 3..5 stay pending, state returns to IDLE.
- **Load strobe:** HSCR2 = 0x05, HBL = 0, SB_HN sweeps 0..15 → SNLD_n[2] low for 8 clocks following SB_HN = 5 and SB_HN = 13 only.
